// File: rtl/trap_vertex_issuer_if.sv
// Vertex-memory read port plus the engine-facing vertex bus of the trapezoid vertex issuer.
// The master side belongs to the issuer; the slave side to the memory/engine pair.
interface trap_vertex_issuer_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              busy;
  logic              po;
  logic              nt;
  logic [7:0]        xi;
  logic [7:0]        yi;
  logic              xy_vld;

  modport master (
    output mem_rd, mem_addr, nt, xi, yi, xy_vld,
    input  mem_data, busy, po
  );

  modport slave (
    input  mem_rd, mem_addr, nt, xi, yi, xy_vld,
    output mem_data, busy, po
  );
endinterface

// File: rtl/trap_vertex_issuer.sv
// Fetches NUM_TRAP four-word vertex groups and hands each to the trapezoid engine when it is idle.
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | four reads of the current group, five cycles including the last data capture
// WAIT  | group buffered, waiting for engine busy low
// SEND  | four consecutive vertices on xi/yi, nt with the first
// FLUSH | all groups issued, waiting for the engine to finish the last one
// DONE  | run complete, done held until next start
module trap_vertex_issuer #(
  parameter int NUM_TRAP  = 17,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int PIX_W     = 18
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  trap_vertex_issuer_if.master bus,
  output logic [ADDR_W-1:0]    o_trap_cnt,
  output logic [PIX_W-1:0]     o_pix_cnt,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic [2:0]        r_cyc, w_cyc;
  logic [15:0]       r_buf [4];
  logic [15:0]       w_buf [4];
  logic              r_mem_rd, w_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic              r_nt, w_nt;
  logic [15:0]       r_xy, w_xy;
  logic              r_vld, w_vld;
  logic [ADDR_W-1:0] r_trap_cnt, w_trap_cnt;
  logic [PIX_W-1:0]  r_pix_cnt, w_pix_cnt;
  logic              r_done, w_done;
  logic [ADDR_W-1:0] w_next_base;
  logic              w_last;

  // trap_cnt doubles as the group index: it equals g whenever a group is being fetched
  assign w_next_base = ADDR_W'(BASE_ADDR) + ((r_trap_cnt + 1'b1) << 2);
  assign w_last      = (int'(r_trap_cnt) + 1) >= NUM_TRAP;

  always_comb begin
    w_state    = r_state;
    w_cyc      = r_cyc;
    w_buf      = r_buf;
    w_mem_rd   = 1'b0;
    w_mem_addr = r_mem_addr;
    w_nt       = 1'b0;
    w_xy       = '0;
    w_vld      = 1'b0;
    w_trap_cnt = r_trap_cnt;
    w_pix_cnt  = r_pix_cnt;
    w_done     = r_done;

    if ((r_state != S_IDLE) && bus.po && (r_pix_cnt != '1)) begin
      w_pix_cnt = r_pix_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state    = S_FETCH;
          w_cyc      = 3'd0;
          w_mem_rd   = 1'b1;
          w_mem_addr = ADDR_W'(BASE_ADDR);
          w_trap_cnt = '0;
          w_pix_cnt  = '0;
          w_done     = 1'b0;
        end
      end
      S_FETCH: begin
        // read data trails the address by one cycle, so capture runs on cycles 1-4
        if (r_cyc != 3'd0) begin
          w_buf[2'(r_cyc - 3'd1)] = bus.mem_data;
        end
        if (r_cyc < 3'd3) begin
          w_mem_rd   = 1'b1;
          w_mem_addr = r_mem_addr + 1'b1;
        end
        if (r_cyc == 3'd4) begin
          w_state = S_WAIT;
        end else begin
          w_cyc = r_cyc + 3'd1;
        end
      end
      S_WAIT: begin
        if (!bus.busy) begin
          w_state = S_SEND;
          w_cyc   = 3'd0;
          w_nt    = 1'b1;
          w_vld   = 1'b1;
          w_xy    = r_buf[0];
        end
      end
      S_SEND: begin
        if (r_cyc != 3'd3) begin
          w_cyc = r_cyc + 3'd1;
          w_vld = 1'b1;
          w_xy  = r_buf[2'(r_cyc + 3'd1)];
        end else begin
          w_trap_cnt = r_trap_cnt + 1'b1;
          if (w_last) begin
            w_state = S_FLUSH;
          end else begin
            w_state    = S_FETCH;
            w_cyc      = 3'd0;
            w_mem_rd   = 1'b1;
            w_mem_addr = w_next_base;
          end
        end
      end
      S_FLUSH: begin
        if (!bus.busy) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cyc      <= 3'd0;
      r_buf      <= '{default: '0};
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_nt       <= 1'b0;
      r_xy       <= '0;
      r_vld      <= 1'b0;
      r_trap_cnt <= '0;
      r_pix_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cyc      <= w_cyc;
      r_buf      <= w_buf;
      r_mem_rd   <= w_mem_rd;
      r_mem_addr <= w_mem_addr;
      r_nt       <= w_nt;
      r_xy       <= w_xy;
      r_vld      <= w_vld;
      r_trap_cnt <= w_trap_cnt;
      r_pix_cnt  <= w_pix_cnt;
      r_done     <= w_done;
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.nt       = r_nt;
  assign bus.xi       = r_xy[15:8];
  assign bus.yi       = r_xy[7:0];
  assign bus.xy_vld   = r_vld;
  assign o_trap_cnt   = r_trap_cnt;
  assign o_pix_cnt    = r_pix_cnt;
  assign o_done       = r_done;

endmodule

// File: tb/tb_trap_vertex_issuer.sv
// Bench for trap_vertex_issuer: a single-group instance with a narrow pixel counter checked
// against a literal cycle table, and a 17-group instance checked every cycle by a stream model.
module tb_trap_vertex_issuer;
  localparam int N = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, start, start_ok, start1;
  logic [7:0]  trap, trap1;
  logic [17:0] pix;
  logic [5:0]  pix1;
  logic        done, done1;
  logic [15:0] mem [256];
  int          n_chk = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;

  // model of the 17-group instance: vertex stream, read stream, pixel count and completion
  int          m_vtx = 0, m_rd = 0, m_run = 0, m_nt = 0, m_fl = 0;
  logic [17:0] m_pix = '0;
  logic        m_active = 1'b0, m_done = 1'b0;

  logic [27:0] tbl [12];
  logic [27:0] got;
  int          stall_bad, po_total, po_dummy;
  logic        seen_nt, hit;

  trap_vertex_issuer_if #(.ADDR_W(8)) b ();
  trap_vertex_issuer_if #(.ADDR_W(8)) b1 ();

  trap_vertex_issuer #(.NUM_TRAP(N), .ADDR_W(8), .BASE_ADDR(0), .PIX_W(18)) u_dut (
    .i_clk(clk), .i_reset(rst_b), .i_start(start), .bus(b),
    .o_trap_cnt(trap), .o_pix_cnt(pix), .o_done(done)
  );

  trap_vertex_issuer #(.NUM_TRAP(1), .ADDR_W(8), .BASE_ADDR(0), .PIX_W(6)) u_dut1 (
    .i_clk(clk), .i_reset(rst_b), .i_start(start1), .bus(b1),
    .o_trap_cnt(trap1), .o_pix_cnt(pix1), .o_done(done1)
  );

  always @(posedge clk) begin
    if (b.mem_rd)  b.mem_data  <= mem[b.mem_addr];
    if (b1.mem_rd) b1.mem_data <= mem[b1.mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] mk(input logic rd, input logic vld, input logic nt,
                                     input logic [15:0] xy, input logic dn, input logic [7:0] tr);
    return {rd, vld, nt, xy, dn, tr};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("trap_cnt", 64'(trap), 64'(m_vtx / 4));
      chk("pix_cnt", 64'(pix), 64'(m_pix));
      chk("done", 64'(done), 64'(m_done));
      if (b.mem_rd) begin
        chk("mem_addr", 64'(b.mem_addr), 64'(m_rd % 256));
        m_rd++;
      end
      if (b.xy_vld) begin
        chk("vertex", 64'({b.xi, b.yi}), 64'(mem[m_vtx % 256]));
        chk("nt_pos", 64'(b.nt), 64'((m_vtx % 4) == 0));
        if (b.nt) m_nt++;
        m_vtx++;
        m_run++;
        if (m_vtx == 4 * N) m_fl = 1;
      end else begin
        chk("idle_bus", 64'({b.nt, b.xi, b.yi}), 64'(0));
        if (m_run != 0) begin
          chk("run_len", 64'(m_run), 64'(4));
          m_run = 0;
        end
      end
      // apply the inputs the next rising edge will sample
      if (!rst_b) begin
        m_vtx = 0; m_rd = 0; m_run = 0; m_nt = 0; m_fl = 0;
        m_pix = '0; m_active = 1'b0; m_done = 1'b0;
      end else if (start && start_ok) begin
        m_vtx = 0; m_rd = 0; m_run = 0; m_nt = 0; m_fl = 0;
        m_pix = '0; m_active = 1'b1; m_done = 1'b0;
      end else begin
        if (m_active && b.po && (m_pix != '1)) m_pix = m_pix + 18'd1;
        if ((m_fl == 2) && !b.busy) begin
          m_done = 1'b1;
          m_fl = 0;
        end else if (m_fl == 1) begin
          m_fl = 2;
        end
      end
    end
  end

  // engine stand-in: busy for the four vertices plus 30 cycles after each nt
  task automatic run_engine(input bit pulse_starts, output int po_cnt);
    int bcnt;
    bcnt = 0;
    po_cnt = 0;
    for (int c = 0; c < 3000 && !m_done; c++) begin
      if (b.nt) bcnt = 34;
      b.busy = (bcnt != 0);
      if (bcnt != 0) bcnt--;
      b.po = ((c % 3) != 2);
      if (b.po) po_cnt++;
      start = pulse_starts && (c == 40 || c == 150 || c == 333);
      @(posedge clk); #1;
    end
    b.po = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      int x, y;
      x = i * 37 + 5;
      y = i * 11 + 3;
      mem[i] = {x[7:0], y[7:0]};
    end
    mem[0] = 16'h1020; mem[1] = 16'h3020; mem[2] = 16'h0050; mem[3] = 16'h4050;
    for (int i = 0; i < 4; i++) tbl[i] = mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 8'd0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 8'd0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 8'd0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 16'h1020, 1'b0, 8'd0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 16'h3020, 1'b0, 8'd0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 16'h0050, 1'b0, 8'd0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 16'h4050, 1'b0, 8'd0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 8'd1);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 16'h0,    1'b1, 8'd1);

    rst_b = 1'b0; start = 1'b0; start_ok = 1'b0; start1 = 1'b0;
    b.busy = 1'b0; b.po = 1'b0; b1.busy = 1'b0; b1.po = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_bus", 64'({b.mem_rd, b.mem_addr, b.nt, b.xi, b.yi, b.xy_vld}), 64'(0));
    chk("rst_cnt", 64'({trap, pix, done}), 64'(0));
    chk("rst_bus1", 64'({b1.mem_rd, b1.mem_addr, b1.nt, b1.xi, b1.yi, b1.xy_vld}), 64'(0));
    chk("rst_cnt1", 64'({trap1, pix1, done1}), 64'(0));
    rst_b = 1'b1;
    mon_en = 1'b1;

    // single trapezoid, busy low: cycle c after the start-accepting edge
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      got = {b1.mem_rd, b1.xy_vld, b1.nt, b1.xi, b1.yi, done1, trap1};
      chk($sformatf("single_c%0d", c), 64'(got), 64'(tbl[c]));
      if (c < 4) chk("single_addr", 64'(b1.mem_addr), 64'(c));
      @(posedge clk); #1;
    end
    chk("single_pix", 64'(pix1), 64'(0));

    // late strobes in DONE count and saturate at 63
    b1.po = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pix1_10", 64'(pix1), 64'(10));
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("pix1_sat", 64'(pix1), 64'(63));
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; b1.po = 1'b0;
    chk("pix1_start_clr", 64'(pix1), 64'(0));
    chk("done1_start_clr", 64'(done1), 64'(0));

    // 17 groups with an initial 20-cycle busy stall
    b.busy = 1'b1; start = 1'b1; start_ok = 1'b1;
    @(posedge clk); #1 start = 1'b0; start_ok = 1'b0;
    stall_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b.xy_vld || b.nt) stall_bad++;
      @(posedge clk); #1;
    end
    chk("stall_quiet", 64'(stall_bad), 64'(0));
    b.busy = 1'b0;
    @(negedge clk);
    chk("stall_hold_nt", 64'(b.nt), 64'(0));
    @(posedge clk); #1;
    chk("stall_release_nt", 64'({b.nt, b.xy_vld}), 64'(2'b11));
    run_engine(1'b1, po_total);
    chk("run_done", 64'(done), 64'(1));
    chk("run_traps", 64'(trap), 64'(N));
    chk("run_nt_count", 64'(m_nt), 64'(N));
    chk("run_vertices", 64'(m_vtx), 64'(4 * N));
    chk("run_reads", 64'(m_rd), 64'(4 * N));
    chk("run_pix", 64'(pix), 64'(po_total));

    // start coincident with po in DONE: the clear wins
    b.busy = 1'b0; start = 1'b1; start_ok = 1'b1; b.po = 1'b1;
    @(posedge clk); #1 start = 1'b0; start_ok = 1'b0; b.po = 1'b0;
    chk("done_start_pix", 64'(pix), 64'(0));
    chk("done_start_done", 64'(done), 64'(0));

    // reset on the edge ending vertex 1 of group 0
    seen_nt = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (seen_nt && b.xy_vld && !b.nt) begin
        rst_b = 1'b0;
        hit = 1'b1;
      end else begin
        seen_nt = b.nt;
        @(posedge clk); #1;
      end
    end
    chk("rst_mid_reached", 64'(hit), 64'(1));
    @(posedge clk); #1 rst_b = 1'b1;
    chk("rst_mid_bus", 64'({b.mem_rd, b.mem_addr, b.nt, b.xi, b.yi, b.xy_vld}), 64'(0));
    chk("rst_mid_cnt", 64'({trap, pix, done}), 64'(0));

    start = 1'b1; start_ok = 1'b1;
    @(posedge clk); #1 start = 1'b0; start_ok = 1'b0;
    chk("restart_rd", 64'(b.mem_rd), 64'(1));
    chk("restart_addr", 64'(b.mem_addr), 64'(0));
    run_engine(1'b0, po_dummy);
    chk("rerun_done", 64'(done), 64'(1));
    chk("rerun_traps", 64'(trap), 64'(N));
    chk("rerun_vertices", 64'(m_vtx), 64'(4 * N));
    chk("rerun_pix", 64'(pix), 64'(po_dummy));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

endmodule
